// File: rtl/prco_alu_wb_pkg.sv
// Shared ISA constants, state encodings and widths for the prco execute/write-back stage.
package prco_alu_wb_pkg;

    localparam int unsigned DW         = 16;
    localparam int unsigned RW         = 3;
    localparam int unsigned MUL_CYCLES = 16;
    localparam int unsigned OPW        = 4;
    localparam int unsigned FW         = 4;
    localparam int unsigned SW         = 2;
    localparam int unsigned SHW        = $clog2(DW);

    localparam logic [OPW-1:0] ALU_ADD = 4'd0;
    localparam logic [OPW-1:0] ALU_SUB = 4'd1;
    localparam logic [OPW-1:0] ALU_AND = 4'd2;
    localparam logic [OPW-1:0] ALU_OR  = 4'd3;
    localparam logic [OPW-1:0] ALU_XOR = 4'd4;
    localparam logic [OPW-1:0] ALU_SHL = 4'd5;
    localparam logic [OPW-1:0] ALU_SHR = 4'd6;
    localparam logic [OPW-1:0] ALU_CMP = 4'd7;
    localparam logic [OPW-1:0] ALU_MOV = 4'd8;
    localparam logic [OPW-1:0] ALU_MUL = 4'd9;

    // Flag vector layout is {Z,N,C,V}
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [SW-1:0] ST_IDLE = 2'd0;
    localparam logic [SW-1:0] ST_EXEC = 2'd1;
    localparam logic [SW-1:0] ST_MUL  = 2'd2;
    localparam logic [SW-1:0] ST_WB   = 2'd3;

    // Single-cycle ops that write their result back to the register set
    function automatic logic alu_op_writes(input logic [OPW-1:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
            ALU_SHL, ALU_SHR, ALU_MOV: alu_op_writes = 1'b1;
            default:                   alu_op_writes = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/prco_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, MUL_CYCLES cycles.
// The product is presented combinationally alongside q_done_c in the final iteration.
module prco_mul_iter
    import prco_alu_wb_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_start,
    input  logic [DW-1:0]   i_a,
    input  logic [DW-1:0]   i_b,
    output logic            q_done_c,
    output logic [2*DW-1:0] q_product_c
);

    localparam int unsigned CW = $clog2(MUL_CYCLES);

    logic            busy;
    logic [CW-1:0]   cnt;
    logic [2*DW-1:0] mcand;
    logic [2*DW-1:0] acc;
    logic [2*DW-1:0] acc_nxt;
    logic [DW-1:0]   mplier;

    always_comb begin
        acc_nxt = mplier[0] ? (acc + mcand) : acc;
    end

    assign q_done_c    = busy && (cnt == CW'(MUL_CYCLES - 1));
    assign q_product_c = acc_nxt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
        end else if (i_start && !busy) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= (2*DW)'(i_a);
            acc    <= '0;
            mplier <= i_b;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (q_done_c) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/prco_alu_wb.sv
// Execute/write-back stage: captures operands from the register set, runs one ALU op,
// writes the result back and pulses completion. Optional multiply: PRCO_ALU_MUL_EN.
module prco_alu_wb
    import prco_alu_wb_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic           i_start,
    input  logic [OPW-1:0] i_op,
    input  logic [RW-1:0]  i_seld,
    input  logic           i_use_imm,
    input  logic [DW-1:0]  i_imm,
    input  logic [DW-1:0]  i_data,
    input  logic [DW-1:0]  i_datb,
    output logic           q_busy,
    output logic           q_we,
    output logic [RW-1:0]  q_seld,
    output logic [DW-1:0]  q_datd,
    output logic           q_ce_done,
    output logic [FW-1:0]  q_flags,
    output logic           q_illegal
);

    logic [SW-1:0]  state, state_nxt;
    logic [OPW-1:0] op_q, op_nxt;
    logic [RW-1:0]  seld_q, seld_nxt;
    logic [DW-1:0]  a_q, a_nxt;
    logic [DW-1:0]  b_q, b_nxt;
    logic [DW-1:0]  b_in_c;

    logic           we_nxt, done_nxt, illegal_nxt;
    logic [RW-1:0]  q_seld_nxt;
    logic [DW-1:0]  q_datd_nxt;
    logic [FW-1:0]  q_flags_nxt;

    logic [DW-1:0]  res_c;
    logic           carry_c, ovf_c, flag_upd_c, illegal_c;
    logic [FW-1:0]  flags_c;
    logic [DW:0]    add_c, sub_c, shl_c, shr_c;
    logic [SHW-1:0] amt_c;

    assign b_in_c = i_use_imm ? i_imm : i_datb;

`ifdef PRCO_ALU_MUL_EN
    logic            mul_start_c;
    logic            mul_done_c;
    logic [2*DW-1:0] mul_prod_c;

    assign mul_start_c = (state == ST_IDLE) && i_start && (i_op == ALU_MUL);

    prco_mul_iter u_mul (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_start     (mul_start_c),
        .i_a         (i_data),
        .i_b         (b_in_c),
        .q_done_c    (mul_done_c),
        .q_product_c (mul_prod_c)
    );
`endif

    // Single-cycle ALU on the latched operands; shifts keep the last bit out in the extra bit
    always_comb begin
        amt_c      = b_q[SHW-1:0];
        add_c      = {1'b0, a_q} + {1'b0, b_q};
        sub_c      = {1'b0, a_q} - {1'b0, b_q};
        shl_c      = {1'b0, a_q} << amt_c;
        shr_c      = {a_q, 1'b0} >> amt_c;
        res_c      = '0;
        carry_c    = 1'b0;
        ovf_c      = 1'b0;
        flag_upd_c = 1'b1;
        illegal_c  = 1'b0;
        case (op_q)
            ALU_ADD: begin
                res_c   = add_c[DW-1:0];
                carry_c = add_c[DW];
                ovf_c   = (a_q[DW-1] == b_q[DW-1]) && (res_c[DW-1] != a_q[DW-1]);
            end
            ALU_SUB, ALU_CMP: begin
                res_c   = sub_c[DW-1:0];
                carry_c = sub_c[DW];
                ovf_c   = (a_q[DW-1] != b_q[DW-1]) && (res_c[DW-1] != a_q[DW-1]);
            end
            ALU_AND: res_c = a_q & b_q;
            ALU_OR:  res_c = a_q | b_q;
            ALU_XOR: res_c = a_q ^ b_q;
            ALU_SHL: begin
                res_c   = shl_c[DW-1:0];
                carry_c = shl_c[DW];
            end
            ALU_SHR: begin
                res_c   = shr_c[DW:1];
                carry_c = shr_c[0];
            end
            ALU_MOV: begin
                res_c      = b_q;
                flag_upd_c = 1'b0;
            end
            default: begin
                flag_upd_c = 1'b0;
                illegal_c  = 1'b1;
            end
        endcase
        flags_c         = '0;
        flags_c[FLAG_Z] = (res_c == '0);
        flags_c[FLAG_N] = res_c[DW-1];
        flags_c[FLAG_C] = carry_c;
        flags_c[FLAG_V] = ovf_c;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt   = state;
        op_nxt      = op_q;
        seld_nxt    = seld_q;
        a_nxt       = a_q;
        b_nxt       = b_q;
        we_nxt      = 1'b0;
        done_nxt    = 1'b0;
        illegal_nxt = 1'b0;
        q_seld_nxt  = q_seld;
        q_datd_nxt  = q_datd;
        q_flags_nxt = q_flags;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    op_nxt    = i_op;
                    seld_nxt  = i_seld;
                    a_nxt     = i_data;
                    b_nxt     = b_in_c;
                    state_nxt = ST_EXEC;
`ifdef PRCO_ALU_MUL_EN
                    if (i_op == ALU_MUL) begin
                        state_nxt = ST_MUL;
                    end
`endif
                end
            end
            ST_EXEC: begin
                state_nxt   = ST_WB;
                done_nxt    = 1'b1;
                illegal_nxt = illegal_c;
                we_nxt      = alu_op_writes(op_q);
                if (we_nxt) begin
                    q_seld_nxt = seld_q;
                    q_datd_nxt = res_c;
                end
                if (flag_upd_c) begin
                    q_flags_nxt = flags_c;
                end
            end
`ifdef PRCO_ALU_MUL_EN
            ST_MUL: begin
                if (mul_done_c) begin
                    state_nxt           = ST_WB;
                    done_nxt            = 1'b1;
                    we_nxt              = 1'b1;
                    q_seld_nxt          = seld_q;
                    q_datd_nxt          = mul_prod_c[DW-1:0];
                    q_flags_nxt[FLAG_Z] = (mul_prod_c[DW-1:0] == '0);
                    q_flags_nxt[FLAG_N] = mul_prod_c[DW-1];
                    q_flags_nxt[FLAG_C] = |mul_prod_c[2*DW-1:DW];
                    q_flags_nxt[FLAG_V] = 1'b0;
                end
            end
`endif
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            seld_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            q_busy    <= 1'b0;
            q_we      <= 1'b0;
            q_ce_done <= 1'b0;
            q_illegal <= 1'b0;
            q_seld    <= '0;
            q_datd    <= '0;
            q_flags   <= '0;
        end else begin
            state     <= state_nxt;
            op_q      <= op_nxt;
            seld_q    <= seld_nxt;
            a_q       <= a_nxt;
            b_q       <= b_nxt;
            q_busy    <= (state_nxt != ST_IDLE);
            q_we      <= we_nxt;
            q_ce_done <= done_nxt;
            q_illegal <= illegal_nxt;
            q_seld    <= q_seld_nxt;
            q_datd    <= q_datd_nxt;
            q_flags   <= q_flags_nxt;
        end
    end

endmodule
